// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding, bus widths, default protection
// attribute and a helper for sizing the ACCESS wait counter.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = 4;

    // Normal, secure, data access.
    localparam logic [2:0] PPROT_DEFAULT = 3'b000;

    // The wait counter only has to reach timeout-1, so log2(timeout) bits suffice.
    function automatic int cnt_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/apb_initiator_reset_sync.sv
// Reset synchroniser: asserts asynchronously with rst_i, releases only after
// two clean clock edges so downstream flops never see a release near an edge.
module reset_sync (
    input  logic clk,
    input  logic rst_i,
    output logic rst
);

    logic [1:0] sync_q;

    // Shift a zero in behind the asynchronous set.
    always_ff @(posedge clk or posedge rst_i) begin
        // NOTE: sequential state is always assigned with <=, so every flop samples
        // pre-edge values regardless of statement order.
        if (rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], 1'b0};
        end
    end

    assign rst = sync_q[1];

endmodule

// File: rtl/apb_initiator.sv
// APB3/APB4 initiator: turns single fabric read/write commands into APB
// SETUP/ACCESS phases and returns data/error on a valid/ready response channel.
module apb_initiator
    import apb_pkg::*;
#(
    parameter int         ADDR_W    = 12,
    parameter int         DATA_W    = APB_DATA_W,
    parameter int         TIMEOUT   = 255,
    parameter logic [2:0] PPROT_VAL = PPROT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_i,
    // command channel
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [APB_STRB_W-1:0] cmd_strb,
    // response channel
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    // APB requester port
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_W-1:0]     paddr,
    output logic [DATA_W-1:0]     pwdata,
    output logic [APB_STRB_W-1:0] pstrb,
    output logic [2:0]            pprot,
    input  logic [DATA_W-1:0]     prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int CNT_W = cnt_width(TIMEOUT);

    logic rst;

    apb_state_e state_q;
    apb_state_e state_d;

    logic [ADDR_W-1:0]     addr_q;
    logic                  write_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [APB_STRB_W-1:0] strb_q;
    logic [CNT_W-1:0]      count_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  err_q;
    logic                  timeout_q;

    logic accept;
    logic timeout_hit;

    reset_sync u_reset_sync (
        .clk   (clk),
        .rst_i (rst_i),
        .rst   (rst)
    );

    assign accept = cmd_valid && cmd_ready;

    // count_q holds the wait cycles already spent, so the current cycle is the
    // TIMEOUT-th one when count_q == TIMEOUT-1. A pready in that cycle still wins.
    assign timeout_hit = (TIMEOUT != 0) && (state_q == ST_ACCESS) && !pready &&
                         (count_q == CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (pready || timeout_hit) state_d = ST_RESP;
            ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Control outputs decoded from the current state.
    always_comb begin
        cmd_ready = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE:   cmd_ready = !rst;
            ST_SETUP:  psel      = 1'b1;
            ST_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            ST_RESP:   rsp_valid = 1'b1;
            default:   ;
        endcase
    end

    // Command capture, wait counter and response capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            count_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= cmd_addr;
                write_q <= cmd_write;
                // Reads never drive write data or strobes onto the bus.
                wdata_q <= cmd_write ? cmd_wdata : '0;
                strb_q  <= cmd_write ? cmd_strb  : '0;
                count_q <= '0;
            end
            if (state_q == ST_ACCESS) begin
                if (pready) begin
                    rdata_q   <= write_q ? '0 : prdata;
                    err_q     <= pslverr;
                    timeout_q <= 1'b0;
                end else if (timeout_hit) begin
                    rdata_q   <= '0;
                    err_q     <= 1'b1;
                    timeout_q <= 1'b1;
                end else begin
                    count_q <= count_q + CNT_W'(1);
                end
            end
            if ((state_q == ST_RESP) && rsp_ready) begin
                count_q <= '0;
            end
        end
    end

    // Payload is only presented while selected, so an async reset clears it too.
    assign pwrite = psel && write_q;
    assign paddr  = psel ? addr_q    : '0;
    assign pwdata = psel ? wdata_q   : '0;
    assign pstrb  = psel ? strb_q    : '0;
    assign pprot  = psel ? PPROT_VAL : 3'b000;

    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = timeout_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Directed testbench for apb_initiator (TIMEOUT=4, PPROT_VAL=3'b010).
module tb_apb_initiator;

    localparam int         ADDR_W = 12;
    localparam logic [2:0] PROT   = 3'b010;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;
    logic [3:0]        cmd_strb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [3:0]        pstrb;
    logic [2:0]        pprot;
    logic [31:0]       prdata;
    logic              pready;
    logic              pslverr;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    apb_initiator #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (32),
        .TIMEOUT   (4),
        .PPROT_VAL (PROT)
    ) dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .pprot       (pprot),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    // Advance one clock and settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command for one edge (DUT must be idle), then withdraw it.
    task automatic issue_cmd(input logic wr, input logic [ADDR_W-1:0] a,
                             input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) tick();
        tests_run++;
        if ({psel, penable, pwrite, cmd_ready, rsp_valid, rsp_err, rsp_timeout} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {psel, penable, pwrite, cmd_ready, rsp_valid, rsp_err, rsp_timeout});
        end
        tests_run++;
        if ({paddr, pwdata, pstrb, pprot, rsp_rdata} !== 83'b0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h expected 0", {paddr, pwdata, pstrb, pprot, rsp_rdata});
        end
        rst_i = 1'b0;
        tick();
        tests_run++;
        if (cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL release_edge1_cmd_ready: got %b expected 0", cmd_ready);
        end
        tick();
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_edge2_cmd_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_zero_wait_write();
        pready  = 1'b1;
        pslverr = 1'b0;
        prdata  = 32'h5555_5555;
        issue_cmd(1'b1, 12'h400, 32'h0000_0001, 4'hF);
        tests_run++;
        if ({psel, penable, pwrite, rsp_valid} !== 4'b1010) begin
            tests_failed++;
            $display("FAIL wr_setup_ctrl: got %b expected 1010", {psel, penable, pwrite, rsp_valid});
        end
        tests_run++;
        if ({paddr, pwdata, pstrb, pprot} !== {12'h400, 32'h1, 4'hF, PROT}) begin
            tests_failed++;
            $display("FAIL wr_setup_bus: got %h expected %h", {paddr, pwdata, pstrb, pprot},
                     {12'h400, 32'h1, 4'hF, PROT});
        end
        tick();
        tests_run++;
        if ({psel, penable, pwrite, paddr, pwdata, pstrb} !== {3'b111, 12'h400, 32'h1, 4'hF}) begin
            tests_failed++;
            $display("FAIL wr_access: got %h expected %h", {psel, penable, pwrite, paddr, pwdata, pstrb},
                     {3'b111, 12'h400, 32'h1, 4'hF});
        end
        tick();
        tests_run++;
        if ({rsp_valid, psel, penable, cmd_ready, rsp_err, rsp_timeout} !== 6'b100000) begin
            tests_failed++;
            $display("FAIL wr_resp_ctrl: got %b expected 100000",
                     {rsp_valid, psel, penable, cmd_ready, rsp_err, rsp_timeout});
        end
        tests_run++;
        if (rsp_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL wr_resp_rdata: got %h expected 00000000", rsp_rdata);
        end
        finish_rsp();
        tests_run++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            tests_failed++;
            $display("FAIL wr_after_handshake: got %b expected 01", {rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_read_wait();
        pready = 1'b0;
        prdata = 32'h0;
        issue_cmd(1'b0, 12'h404, 32'hFFFF_FFFF, 4'hF);
        tests_run++;
        if ({psel, penable, pwrite, paddr, pwdata, pstrb, pprot} !== {3'b100, 12'h404, 32'h0, 4'h0, PROT}) begin
            tests_failed++;
            $display("FAIL rd_setup: got %h expected %h", {psel, penable, pwrite, paddr, pwdata, pstrb, pprot},
                     {3'b100, 12'h404, 32'h0, 4'h0, PROT});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) begin
                pready = 1'b1;
                prdata = 32'hDEAD_BEEF;
            end
            tests_run++;
            if ({psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid} !== {3'b110, 12'h404, 32'h0, 4'h0, 1'b0}) begin
                tests_failed++;
                $display("FAIL rd_access_%0d: got %h expected %h", i,
                         {psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid},
                         {3'b110, 12'h404, 32'h0, 4'h0, 1'b0});
            end
        end
        tick();
        pready = 1'b0;
        tests_run++;
        if ({rsp_valid, psel, rsp_err, rsp_timeout, rsp_rdata} !== {4'b1000, 32'hDEAD_BEEF}) begin
            tests_failed++;
            $display("FAIL rd_resp: got %h expected %h", {rsp_valid, psel, rsp_err, rsp_timeout, rsp_rdata},
                     {4'b1000, 32'hDEAD_BEEF});
        end
        finish_rsp();
    endtask

    task automatic test_slave_error();
        pready  = 1'b1;
        pslverr = 1'b1;
        issue_cmd(1'b1, 12'h408, 32'h0000_00AA, 4'h3);
        tick();
        tick();
        pslverr = 1'b0;
        tests_run++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110) begin
            tests_failed++;
            $display("FAIL err_resp: got %b expected 110", {rsp_valid, rsp_err, rsp_timeout});
        end
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 12'h40C;
        prdata    = 32'h0BAD_F00D;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests_run++;
            if ({cmd_ready, psel, rsp_valid} !== 3'b001) begin
                tests_failed++;
                $display("FAIL err_hold_%0d: got %b expected 001", i, {cmd_ready, psel, rsp_valid});
            end
        end
        finish_rsp();
        tests_run++;
        if ({cmd_ready, psel, rsp_valid} !== 3'b100) begin
            tests_failed++;
            $display("FAIL err_idle_gap: got %b expected 100", {cmd_ready, psel, rsp_valid});
        end
        tick();
        cmd_valid = 1'b0;
        tests_run++;
        if ({psel, penable, paddr} !== {2'b10, 12'h40C}) begin
            tests_failed++;
            $display("FAIL err_next_setup: got %h expected %h", {psel, penable, paddr}, {2'b10, 12'h40C});
        end
        tick();
        tick();
        tests_run++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h0BAD_F00D}) begin
            tests_failed++;
            $display("FAIL err_next_resp: got %h expected %h", {rsp_valid, rsp_err, rsp_rdata},
                     {2'b10, 32'h0BAD_F00D});
        end
        finish_rsp();
    endtask

    task automatic test_timeout();
        pready = 1'b0;
        prdata = 32'h1234_5678;
        issue_cmd(1'b0, 12'h410, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if ({psel, penable, rsp_valid} !== 3'b110) begin
                tests_failed++;
                $display("FAIL to_wait_%0d: got %b expected 110", i, {psel, penable, rsp_valid});
            end
        end
        tick();
        tests_run++;
        if ({psel, penable, rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {5'b00111, 32'h0}) begin
            tests_failed++;
            $display("FAIL to_abort: got %h expected %h", {psel, penable, rsp_valid, rsp_err, rsp_timeout, rsp_rdata},
                     {5'b00111, 32'h0});
        end
        finish_rsp();
        prdata = 32'h0;
        issue_cmd(1'b0, 12'h414, 32'h0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) begin
                pready = 1'b1;
                prdata = 32'hCAFE_F00D;
            end
        end
        tick();
        pready = 1'b0;
        tests_run++;
        if ({psel, rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {4'b0100, 32'hCAFE_F00D}) begin
            tests_failed++;
            $display("FAIL to_pready_wins: got %h expected %h", {psel, rsp_valid, rsp_err, rsp_timeout, rsp_rdata},
                     {4'b0100, 32'hCAFE_F00D});
        end
        finish_rsp();
    endtask

    task automatic test_back_to_back();
        pready = 1'b1;
        issue_cmd(1'b1, 12'h418, 32'hA5A5_A5A5, 4'hF);
        tick();
        tick();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 12'h41C;
        prdata    = 32'h0000_0041;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests_run++;
            if ({cmd_ready, psel, penable, rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {6'b000100, 32'h0}) begin
                tests_failed++;
                $display("FAIL bp_hold_%0d: got %h expected %h", i,
                         {cmd_ready, psel, penable, rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {6'b000100, 32'h0});
            end
        end
        finish_rsp();
        tests_run++;
        if ({cmd_ready, psel, rsp_valid} !== 3'b100) begin
            tests_failed++;
            $display("FAIL bp_idle_gap: got %b expected 100", {cmd_ready, psel, rsp_valid});
        end
        tick();
        cmd_valid = 1'b0;
        tests_run++;
        if ({psel, penable, pwrite, paddr} !== {3'b100, 12'h41C}) begin
            tests_failed++;
            $display("FAIL bp_next_setup: got %h expected %h", {psel, penable, pwrite, paddr}, {3'b100, 12'h41C});
        end
        tick();
        tick();
        tests_run++;
        if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h0000_0041}) begin
            tests_failed++;
            $display("FAIL bp_next_resp: got %h expected %h", {rsp_valid, rsp_rdata}, {1'b1, 32'h0000_0041});
        end
        finish_rsp();
    endtask

    task automatic test_reset_mid_access();
        pready = 1'b0;
        issue_cmd(1'b1, 12'h420, 32'h0000_0077, 4'hF);
        tick();
        tests_run++;
        if ({psel, penable} !== 2'b11) begin
            tests_failed++;
            $display("FAIL rst_pre_access: got %b expected 11", {psel, penable});
        end
        #1 rst_i = 1'b1;
        #1;
        tests_run++;
        if ({psel, penable, rsp_valid, cmd_ready, paddr} !== {4'b0000, 12'h0}) begin
            tests_failed++;
            $display("FAIL rst_async_drop: got %h expected %h", {psel, penable, rsp_valid, cmd_ready, paddr},
                     {4'b0000, 12'h0});
        end
        pready = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
        tick();
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_release_ready: got %b expected 1", cmd_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if ({psel, rsp_valid} !== 2'b00) begin
                tests_failed++;
                $display("FAIL rst_no_stale_%0d: got %b expected 00", i, {psel, rsp_valid});
            end
        end
        pready = 1'b0;
    endtask

    initial begin
        rst_i     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b0;
        prdata    = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        test_reset();
        test_zero_wait_write();
        test_read_wait();
        test_slave_error();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete within 50000 time units");
        $fatal(1);
    end

endmodule
